poly_bram_streamer: RTL and testbench

//  Host-side port to the 64x96-bit polynomial BRAMs used by the NTT/mult/add datapath.

---
 rtl/poly_bram_streamer.sv | 224 ++++++++++++++++++++++
 tb/tb_poly_bram_streamer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_bram_streamer.sv
// poly_bram_streamer
//   Host-side port to a 64 x 96-bit polynomial BRAM.
//   LOAD   : accepts a coefficient stream and packs four coefficients per word.
//            Each finished word is written through port B, addresses 0..N_WORDS-1.
//   UNLOAD : reads the words back through port A (one-cycle read latency) and
//            streams the coefficients out with valid/ready backpressure.
//   Coefficient i lives in word i>>2, lane i%4 (lane 0 = least significant).
// Ports
//   clk, rst (async, active-low) | start, dir (0 LOAD / 1 UNLOAD), abort
//   busy, done                    | s_data/s_valid/s_ready (LOAD input stream)
//   m_data/m_valid/m_ready/m_last (UNLOAD output stream)
//   addra/doa (BRAM read port)    | addrb/web/dib (BRAM write port)
module poly_bram_streamer #(
  parameter int COEFF_W = 24,
  parameter int N_WORDS = 64,
  parameter int ADDR_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 dir,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  input  logic [COEFF_W-1:0]   s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [COEFF_W-1:0]   m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic [ADDR_W-1:0]    addra,
  input  logic [4*COEFF_W-1:0] doa,
  output logic [ADDR_W-1:0]    addrb,
  output logic                 web,
  output logic [4*COEFF_W-1:0] dib
);

  localparam int WORD_W = 4 * COEFF_W;
  localparam int CNT_W  = ADDR_W + 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_WORDS - 1);
  localparam logic [CNT_W-1:0]  LAST_COEFF = CNT_W'(4 * N_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UNLOAD, S_FLUSH} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    ld_cnt_q, ld_cnt_d;
  logic [WORD_W-1:0]   stage_q, stage_d;
  logic                web_q, web_d;
  logic [ADDR_W-1:0]   addrb_q, addrb_d;
  logic [WORD_W-1:0]   dib_q, dib_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_pend_q, rd_pend_d;
  logic [WORD_W-1:0]   buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;

  logic                last_wr, s_acc, m_fire, pop;
  logic [1:0]          occ;

  // The word-63 write cycle closes the input side; no coefficient past 255 is taken.
  assign last_wr = web_q && (addrb_q == LAST_ADDR);
  assign s_ready = (state_q == S_LOAD) && !last_wr;
  assign s_acc   = s_valid && s_ready;

  assign m_valid = ((state_q == S_UNLOAD) || (state_q == S_FLUSH)) && (bcnt_q != 2'd0);
  assign m_data  = m_valid ? buf0_q[int'(out_cnt_q[1:0]) * COEFF_W +: COEFF_W] : '0;
  assign m_last  = m_valid && (out_cnt_q == LAST_COEFF);
  assign m_fire  = m_valid && m_ready;
  // The head word leaves the buffer once its lane 3 is handed over.
  assign pop     = m_fire && (out_cnt_q[1:0] == 2'd3);
  // Words held plus the read in flight; caps read-ahead at two words.
  assign occ     = bcnt_q + {1'b0, rd_pend_q};

  // rd_addr wraps to 0 after issuing the last word, so IDLE always presents addra=0.
  assign addra = rd_addr_q;
  assign addrb = addrb_q;
  assign web   = web_q;
  assign dib   = dib_q;
  assign done  = done_q;
  assign busy  = (state_q != S_IDLE);

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    stage_d   = stage_q;
    web_d     = 1'b0;
    addrb_d   = addrb_q;
    dib_d     = dib_q;
    done_d    = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_pend_d = 1'b0;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    bcnt_d    = bcnt_q;
    out_cnt_d = out_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ld_cnt_d  = '0;
          stage_d   = '0;
          out_cnt_d = '0;
          bcnt_d    = '0;
          if (dir) begin
            // Word 0 is read in the accept cycle itself.
            state_d   = S_UNLOAD;
            rd_pend_d = 1'b1;
            rd_addr_d = rd_addr_q + 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (s_acc) begin
          stage_d[int'(ld_cnt_q[1:0]) * COEFF_W +: COEFF_W] = s_data;
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (ld_cnt_q[1:0] == 2'd3) begin
            web_d   = 1'b1;
            addrb_d = ld_cnt_q[CNT_W-1:2];
            dib_d   = stage_d;
          end
        end
        if (last_wr) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_UNLOAD, S_FLUSH: begin
        if ((state_q == S_UNLOAD) && (occ < 2'd2)) begin
          rd_pend_d = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          if (rd_addr_q == LAST_ADDR) state_d = S_FLUSH;
        end

        // Two-entry FIFO: buf0 is the head, buf1 the tail.
        unique case ({rd_pend_q, pop})
          2'b10: begin
            if (bcnt_q == 2'd0) buf0_d = doa;
            else                buf1_d = doa;
            bcnt_d = bcnt_q + 2'd1;
          end
          2'b01: begin
            buf0_d = buf1_q;
            bcnt_d = bcnt_q - 2'd1;
          end
          2'b11: begin
            if (bcnt_q == 2'd1) begin
              buf0_d = doa;
            end else begin
              buf0_d = buf1_q;
              buf1_d = doa;
            end
          end
          default: ;
        endcase

        if (m_fire) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (out_cnt_q == LAST_COEFF) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            bcnt_d  = '0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a start in the same cycle.
    if (abort) begin
      state_d   = S_IDLE;
      web_d     = 1'b0;
      done_d    = 1'b0;
      rd_pend_d = 1'b0;
      rd_addr_d = '0;
      bcnt_d    = '0;
      ld_cnt_d  = '0;
      out_cnt_d = '0;
      stage_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ld_cnt_q  <= '0;
      stage_q   <= '0;
      web_q     <= 1'b0;
      addrb_q   <= '0;
      dib_q     <= '0;
      done_q    <= 1'b0;
      rd_addr_q <= '0;
      rd_pend_q <= 1'b0;
      // NOTE: the read buffer is plain registers, not RAM, so clearing it on reset is cheap and keeps outputs at 0.
      buf0_q    <= '0;
      buf1_q    <= '0;
      bcnt_q    <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      stage_q   <= stage_d;
      web_q     <= web_d;
      addrb_q   <= addrb_d;
      dib_q     <= dib_d;
      done_q    <= done_d;
      rd_addr_q <= rd_addr_d;
      rd_pend_q <= rd_pend_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      bcnt_q    <= bcnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_poly_bram_streamer.sv
// tb_poly_bram_streamer
//   Directed sequence of LOAD / UNLOAD transfers against poly_bram_streamer.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on the
//   falling edge. Expected words and coefficients come from plain arrays and
//   the word/lane packing rule.
module tb_poly_bram_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, dir = 1'b0, abort = 1'b0;
  logic        busy, done;
  logic [23:0] s_data = '0;
  logic        s_valid = 1'b0, s_ready;
  logic [23:0] m_data;
  logic        m_valid, m_last;
  logic        m_ready = 1'b0;
  logic [5:0]  addra, addrb;
  logic [95:0] doa = '0;
  logic        web;
  logic [95:0] dib;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [23:0] src  [256];
  logic [95:0] rmem [64];

  poly_bram_streamer dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .abort(abort),
    .busy(busy), .done(done),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .addra(addra), .doa(doa), .addrb(addrb), .web(web), .dib(dib)
  );

  always #5 clk = ~clk;

  // Synchronous-read BRAM model for the UNLOAD side.
  always @(posedge clk) doa <= rmem[addra];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] pack_src(input int w);
    logic [95:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) r[24*l +: 24] = src[4*w + l];
    return r;
  endfunction

  function automatic logic [23:0] coeff_of(input int i);
    logic [95:0] w;
    w = rmem[i / 4];
    return w[24*(i % 4) +: 24];
  endfunction

  // Full LOAD of src[]; gap_pct = chance of s_valid low, pulse_start re-pulses start mid-transfer.
  task automatic run_load(input int gap_pct, input bit pulse_start, input bit spec_words);
    int idx = 0, nwr = 0, cyc = 0, done_cyc = -1, last_wr_cyc = -100;
    logic [95:0] w0 = '0, w63 = '0;
    start = 1'b1; dir = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    tick();
    start = 1'b0;
    cyc = 1;
    while (done_cyc < 0 && cyc < 2000) begin
      s_valid = (idx < 256) && (int'($urandom_range(99)) >= gap_pct);
      s_data  = (idx < 256) ? src[idx] : 24'($urandom);
      if (pulse_start && idx == 100) begin start = 1'b1; dir = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      if (web) begin
        check("ld_wr_addr", 96'(addrb), 96'(nwr));
        if (nwr < 64) check("ld_wr_data", dib, pack_src(nwr));
        if (nwr == 0)  w0  = dib;
        if (nwr == 63) begin w63 = dib; last_wr_cyc = cyc; end
        nwr++;
      end
      if (done) begin
        done_cyc = cyc;
        check("ld_sready_at_done", 96'(s_ready), 96'(0));
      end
      if (s_valid && s_ready) idx++;
      tick();
      cyc++;
    end
    start = 1'b0; s_valid = 1'b0;
    check("ld_write_count", 96'(nwr), 96'(64));
    check("ld_done_after_w63", 96'(done_cyc), 96'(last_wr_cyc + 1));
    if (gap_pct == 0) check("ld_total_cycles", 96'(done_cyc), 96'(258));
    if (spec_words) begin
      check("ld_word0", w0, {24'd3, 24'd2, 24'd1, 24'd0});
      check("ld_word63", w63, {24'd255, 24'd254, 24'd253, 24'd252});
    end
    @(negedge clk);
    check("ld_busy_after", 96'(busy), 96'(0));
    tick();
  endtask

  // UNLOAD of rmem[]; ready_pct = chance of m_ready high; abort_at >= 0 aborts at that coefficient.
  task automatic run_unload(input int ready_pct, input int abort_at);
    int k = 0, cyc = 0, first_valid = -1, done_cyc = -1, last_fire = -100, ahead;
    bit prev_stall = 1'b0;
    logic [23:0] prev_data = '0;
    logic prev_last = 1'b0;
    start = 1'b1; dir = 1'b1; m_ready = 1'b0;
    @(negedge clk);
    check("ul_addra_cycle0", 96'(addra), 96'(0));
    tick();
    start = 1'b0;
    cyc = 1;
    while (done_cyc < 0 && cyc < 3000) begin
      m_ready = (int'($urandom_range(99)) < ready_pct);
      if (abort_at >= 0 && k == abort_at) begin
        abort = 1'b1; start = 1'b1; dir = 1'b0;
        tick();
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        check("ab_mvalid", 96'(m_valid), 96'(0));
        check("ab_busy", 96'(busy), 96'(0));
        check("ab_done", 96'(done), 96'(0));
        for (int i = 0; i < 6; i++) begin
          tick();
          @(negedge clk);
          check("ab_stay_idle", 96'({busy, done, m_valid, web}), 96'(0));
        end
        tick();
        m_ready = 1'b0;
        return;
      end
      @(negedge clk);
      if (prev_stall) begin
        check("ul_hold_valid", 96'(m_valid), 96'(1));
        check("ul_hold_data", 96'(m_data), 96'(prev_data));
        check("ul_hold_last", 96'(m_last), 96'(prev_last));
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (busy && !(addra == 6'd0 && k >= 4)) begin
        ahead = int'(addra) - k / 4;
        check("ul_readahead", 96'(ahead >= 0 && ahead <= 2), 96'(1));
      end
      if (done) begin
        done_cyc = cyc;
        check("ul_mvalid_at_done", 96'(m_valid), 96'(0));
      end
      if (m_valid && m_ready) begin
        if (k < 256) check("ul_data", 96'(m_data), 96'(coeff_of(k)));
        check("ul_last", 96'(m_last), 96'(k == 255));
        if (k == 255) last_fire = cyc;
        k++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      tick();
      cyc++;
    end
    m_ready = 1'b0;
    check("ul_count", 96'(k), 96'(256));
    check("ul_done_after_last", 96'(done_cyc), 96'(last_fire + 1));
    if (ready_pct >= 100) begin
      check("ul_first_valid", 96'(first_valid), 96'(2));
      check("ul_done_cycle", 96'(done_cyc), 96'(258));
    end
  endtask

  initial begin
    int idx, cyc;
    bit saw_w32;
    for (int i = 0; i < 256; i++) src[i] = 24'(i);
    for (int w = 0; w < 64; w++) rmem[w] = pack_src(w);

    // Reset state
    #2;
    @(negedge clk);
    check("rst_outputs", 96'({busy, done, s_ready, m_valid, m_last, web}), 96'(0));
    check("rst_data", {m_data, addra, addrb, 2'b00}, 96'(0));
    check("rst_dib", dib, 96'(0));
    tick();
    rst = 1'b1;
    tick();

    // 1: sequential LOAD
    run_load(0, 1'b0, 1'b1);

    // 2: UNLOAD of the same image, sink always ready
    run_unload(100, -1);

    // 3: UNLOAD of random data, sink ready 50%
    for (int w = 0; w < 64; w++) rmem[w] = {$urandom, $urandom, $urandom};
    run_unload(50, -1);

    // 4: LOAD with s_valid gaps and a second start mid-transfer
    run_load(30, 1'b1, 1'b1);

    // 5: reset after 130 coefficients
    idx = 0; cyc = 0; saw_w32 = 1'b0;
    start = 1'b1; dir = 1'b0;
    @(negedge clk);
    tick();
    start = 1'b0;
    while (idx < 130 && cyc < 500) begin
      s_valid = 1'b1;
      s_data  = src[idx];
      @(negedge clk);
      if (web && addrb == 6'd32) saw_w32 = 1'b1;
      if (s_valid && s_ready) idx++;
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst5_outputs", 96'({busy, done, s_ready, m_valid, m_last, web}), 96'(0));
    check("rst5_data", {m_data, addra, addrb, 2'b00}, 96'(0));
    check("rst5_dib", dib, 96'(0));
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (web) saw_w32 = 1'b1;
      tick();
    end
    check("rst5_no_word32", 96'(saw_w32), 96'(0));
    check("rst5_busy", 96'(busy), 96'(0));
    run_load(0, 1'b0, 1'b1);

    // 6: abort during UNLOAD at coefficient 40, with start in the same cycle
    for (int w = 0; w < 64; w++) rmem[w] = pack_src(w);
    run_unload(100, 40);

    // Recovery after abort: a normal UNLOAD works again
    for (int w = 0; w < 64; w++) rmem[w] = {$urandom, $urandom, $urandom};
    run_unload(70, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
